// File: rtl/scv_rominit_if.sv
// ROM-initialisation stream and memory write-port bundle for scv_rominit.
// The master side is the loader/bench; the slave side is the receiver.
interface scv_rominit_if #(
  parameter int unsigned BOOT_AW = 12,
  parameter int unsigned CHR_AW  = 10,
  parameter int unsigned CART_AW = 17
);
  logic                 ROMINIT_SEL_BOOT;
  logic                 ROMINIT_SEL_CHR;
  logic                 ROMINIT_SEL_CART;
  logic [24:0]          ROMINIT_ADDR;
  logic [7:0]           ROMINIT_DATA;
  logic                 ROMINIT_VALID;
  logic [7:0]           WDATA;
  logic                 BOOT_WE;
  logic [BOOT_AW-1:0]   BOOT_A;
  logic                 CHR_WE;
  logic [CHR_AW-1:0]    CHR_A;
  logic                 CART_WE;
  logic [CART_AW-1:0]   CART_A;
  logic                 BUSY;
  logic [2:0]           LOADED;
  logic [CART_AW:0]     CART_LEN;
  logic [2:0]           ERR;
  logic [15:0]          CKSUM;

  modport master (
    output ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_CART,
           ROMINIT_ADDR, ROMINIT_DATA, ROMINIT_VALID,
    input  WDATA, BOOT_WE, BOOT_A, CHR_WE, CHR_A, CART_WE, CART_A,
           BUSY, LOADED, CART_LEN, ERR, CKSUM
  );

  modport slave (
    input  ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_CART,
           ROMINIT_ADDR, ROMINIT_DATA, ROMINIT_VALID,
    output WDATA, BOOT_WE, BOOT_A, CHR_WE, CHR_A, CART_WE, CART_A,
           BUSY, LOADED, CART_LEN, ERR, CKSUM
  );
endinterface

// File: rtl/scv_rominit.sv
// ROM-init stream receiver: registered write strobes for boot/CHR/cart memories,
// per-region load status, cart length and error flags. Define SCV_ROMINIT_CKSUM_EN for CKSUM.
module scv_rominit #(
  parameter int unsigned BOOT_AW = 12,
  parameter int unsigned CHR_AW  = 10,
  parameter int unsigned CART_AW = 17
) (
  input  logic         CLK,
  input  logic         RES,
  scv_rominit_if.slave bus
);
  localparam int unsigned ADDR_W = 25;
  localparam int unsigned CNT_W  = CART_AW + 1;
  localparam logic [1:0]  RGN_BOOT = 2'd0;
  localparam logic [1:0]  RGN_CHR  = 2'd1;
  localparam logic [1:0]  RGN_CART = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FINISH} state_e;

  state_e              state_q, state_d;
  logic [1:0]          rgn_q, rgn_d;
  logic [ADDR_W-1:0]   expect_q, expect_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                boot_we_q, boot_we_d, chr_we_q, chr_we_d, cart_we_q, cart_we_d;
  logic [BOOT_AW-1:0]  boot_a_q, boot_a_d;
  logic [CHR_AW-1:0]   chr_a_q, chr_a_d;
  logic [CART_AW-1:0]  cart_a_q, cart_a_d;
  logic                busy_q, busy_d;
  logic [2:0]          loaded_q, loaded_d;
  logic [CNT_W-1:0]    cart_len_q, cart_len_d;
  logic [2:0]          err_q, err_d;
`ifdef SCV_ROMINIT_CKSUM_EN
  logic [15:0]         sum_q, sum_d;
  logic [15:0]         cksum_q, cksum_d;
`endif

  logic [2:0] sel, rgn_mask;
  logic       sel_multi, sel_one, rgn_sel, other_sel, addr_over;
  logic [1:0] sel_rgn;

  assign sel       = {bus.ROMINIT_SEL_CART, bus.ROMINIT_SEL_CHR, bus.ROMINIT_SEL_BOOT};
  assign sel_multi = (sel & (sel - 3'd1)) != 3'd0;
  assign sel_one   = (sel != 3'd0) && !sel_multi;
  assign sel_rgn   = sel[0] ? RGN_BOOT : (sel[1] ? RGN_CHR : RGN_CART);
  assign rgn_mask  = 3'b001 << rgn_q;
  assign rgn_sel   = |(sel & rgn_mask);
  assign other_sel = |(sel & ~rgn_mask);

  // Address lies beyond the latched region's memory
  always_comb begin
    addr_over = 1'b0;
    case (rgn_q)
      RGN_BOOT: addr_over = (bus.ROMINIT_ADDR >> BOOT_AW) != '0;
      RGN_CHR:  addr_over = (bus.ROMINIT_ADDR >> CHR_AW) != '0;
      default:  addr_over = (bus.ROMINIT_ADDR >> CART_AW) != '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q    <= S_IDLE;
      rgn_q      <= RGN_BOOT;
      expect_q   <= '0;
      count_q    <= '0;
      wdata_q    <= '0;
      boot_we_q  <= 1'b0;
      chr_we_q   <= 1'b0;
      cart_we_q  <= 1'b0;
      boot_a_q   <= '0;
      chr_a_q    <= '0;
      cart_a_q   <= '0;
      busy_q     <= 1'b0;
      loaded_q   <= '0;
      cart_len_q <= '0;
      err_q      <= '0;
`ifdef SCV_ROMINIT_CKSUM_EN
      sum_q      <= '0;
      cksum_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rgn_q      <= rgn_d;
      expect_q   <= expect_d;
      count_q    <= count_d;
      wdata_q    <= wdata_d;
      boot_we_q  <= boot_we_d;
      chr_we_q   <= chr_we_d;
      cart_we_q  <= cart_we_d;
      boot_a_q   <= boot_a_d;
      chr_a_q    <= chr_a_d;
      cart_a_q   <= cart_a_d;
      busy_q     <= busy_d;
      loaded_q   <= loaded_d;
      cart_len_q <= cart_len_d;
      err_q      <= err_d;
`ifdef SCV_ROMINIT_CKSUM_EN
      sum_q      <= sum_d;
      cksum_q    <= cksum_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    rgn_d      = rgn_q;
    expect_d   = expect_q;
    count_d    = count_q;
    wdata_d    = wdata_q;
    boot_we_d  = 1'b0;
    chr_we_d   = 1'b0;
    cart_we_d  = 1'b0;
    boot_a_d   = boot_a_q;
    chr_a_d    = chr_a_q;
    cart_a_d   = cart_a_q;
    loaded_d   = loaded_q;
    cart_len_d = cart_len_q;
    err_d      = err_q;
`ifdef SCV_ROMINIT_CKSUM_EN
    sum_d      = sum_q;
    cksum_d    = cksum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (sel_multi) begin
          err_d[2] = 1'b1;
        end else if (sel_one) begin
          state_d  = S_LOAD;
          rgn_d    = sel_rgn;
          expect_d = '0;
          count_d  = '0;
          loaded_d = loaded_q & ~sel;
`ifdef SCV_ROMINIT_CKSUM_EN
          sum_d    = '0;
`endif
        end
      end
      S_LOAD: begin
        // Dropping the latched select ends the load; a coincident beat is discarded
        if (!rgn_sel) begin
          state_d = S_FINISH;
        end else begin
          if (other_sel) err_d[2] = 1'b1;
          if (bus.ROMINIT_VALID) begin
            if (bus.ROMINIT_ADDR != expect_q) err_d[1] = 1'b1;
            expect_d = bus.ROMINIT_ADDR + ADDR_W'(1);
            if (addr_over) begin
              err_d[0] = 1'b1;
            end else begin
              wdata_d = bus.ROMINIT_DATA;
              case (rgn_q)
                RGN_BOOT: begin
                  boot_we_d = 1'b1;
                  boot_a_d  = bus.ROMINIT_ADDR[BOOT_AW-1:0];
                end
                RGN_CHR: begin
                  chr_we_d = 1'b1;
                  chr_a_d  = bus.ROMINIT_ADDR[CHR_AW-1:0];
                end
                default: begin
                  cart_we_d = 1'b1;
                  cart_a_d  = bus.ROMINIT_ADDR[CART_AW-1:0];
                end
              endcase
              if (count_q != '1) count_d = count_q + CNT_W'(1);
`ifdef SCV_ROMINIT_CKSUM_EN
              sum_d = sum_q + 16'(bus.ROMINIT_DATA);
`endif
            end
          end
        end
      end
      S_FINISH: begin
        state_d  = S_IDLE;
        loaded_d = loaded_q | rgn_mask;
        if (rgn_q == RGN_CART) cart_len_d = count_q;
`ifdef SCV_ROMINIT_CKSUM_EN
        cksum_d  = sum_q;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign bus.WDATA    = wdata_q;
  assign bus.BOOT_WE  = boot_we_q;
  assign bus.BOOT_A   = boot_a_q;
  assign bus.CHR_WE   = chr_we_q;
  assign bus.CHR_A    = chr_a_q;
  assign bus.CART_WE  = cart_we_q;
  assign bus.CART_A   = cart_a_q;
  assign bus.BUSY     = busy_q;
  assign bus.LOADED   = loaded_q;
  assign bus.CART_LEN = cart_len_q;
  assign bus.ERR      = err_q;
`ifdef SCV_ROMINIT_CKSUM_EN
  assign bus.CKSUM    = cksum_q;
`else
  assign bus.CKSUM    = 16'd0;
`endif
endmodule

// File: tb/tb_scv_rominit.sv
// Scoreboard bench for scv_rominit: stimulus pushes expected writes/status,
// a negedge monitor pops and compares them against the DUT.
module tb_scv_rominit;
  localparam int unsigned BOOT_AW = 12;
  localparam int unsigned CHR_AW  = 10;
  localparam int unsigned CART_AW = 17;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  scv_rominit_if #(.BOOT_AW(BOOT_AW), .CHR_AW(CHR_AW), .CART_AW(CART_AW)) bus ();

  scv_rominit #(.BOOT_AW(BOOT_AW), .CHR_AW(CHR_AW), .CART_AW(CART_AW)) dut (
    .CLK (clk),
    .RES (res),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [1:0]  rgn;
    logic [16:0] a;
    logic [7:0]  d;
  } wr_t;

  typedef struct {
    int          kind;      // 0 = status check, 1 = end of run
    string       name;
    logic [2:0]  loaded;
    logic [2:0]  err;
    logic        busy;
    logic [17:0] cart_len;
    logic [15:0] cksum;
    int          wr0, wr1, wr2;
    bit          zero_bus;
  } stat_t;

  wr_t   wq[$];
  stat_t sq[$];

  int tests = 0;
  int fails = 0;
  int seen[3];

  // Reference model state
  logic [1:0]  m_rgn;
  logic [24:0] m_expect;
  logic [17:0] m_count;
  int          m_sum;
  logic [2:0]  m_loaded, m_err;
  logic [17:0] m_cart_len;
  logic [15:0] m_cksum;
  int          m_wr[3];

  function automatic int aw_of(input logic [1:0] r);
    case (r)
      2'd0:    return int'(BOOT_AW);
      2'd1:    return int'(CHR_AW);
      default: return int'(CART_AW);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every write strobe and every status snapshot
  always @(negedge clk) begin
    wr_t   obs, e;
    stat_t s;
    int    nwe;
    nwe = int'(bus.BOOT_WE) + int'(bus.CHR_WE) + int'(bus.CART_WE);
    if (nwe > 0) begin
      chk("one_we", 32'(nwe), 32'd1);
      if (bus.BOOT_WE)     obs = '{rgn: 2'd0, a: 17'(bus.BOOT_A), d: bus.WDATA};
      else if (bus.CHR_WE) obs = '{rgn: 2'd1, a: 17'(bus.CHR_A),  d: bus.WDATA};
      else                 obs = '{rgn: 2'd2, a: bus.CART_A,      d: bus.WDATA};
      seen[obs.rgn]++;
      if (wq.size() == 0) begin
        chk("unexpected_write", 32'(obs), 32'hFFFF_FFFF);
      end else begin
        e = wq.pop_front();
        chk("write", 32'(obs), 32'(e));
      end
    end
    if (sq.size() > 0) begin
      s = sq.pop_front();
      if (s.kind == 1) begin
        chk("pending_writes", 32'(wq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end else begin
        chk({s.name, ".loaded"},   32'(bus.LOADED),   32'(s.loaded));
        chk({s.name, ".err"},      32'(bus.ERR),      32'(s.err));
        chk({s.name, ".busy"},     32'(bus.BUSY),     32'(s.busy));
        chk({s.name, ".cart_len"}, 32'(bus.CART_LEN), 32'(s.cart_len));
        chk({s.name, ".cksum"},    32'(bus.CKSUM),    32'(s.cksum));
        chk({s.name, ".boot_we_n"}, 32'(seen[0]), 32'(s.wr0));
        chk({s.name, ".chr_we_n"},  32'(seen[1]), 32'(s.wr1));
        chk({s.name, ".cart_we_n"}, 32'(seen[2]), 32'(s.wr2));
        seen[0] = 0; seen[1] = 0; seen[2] = 0;
        if (s.zero_bus) begin
          chk({s.name, ".addrs"}, 32'({bus.BOOT_A, bus.CHR_A} | 22'(bus.CART_A)), 32'd0);
          chk({s.name, ".wdata"}, 32'(bus.WDATA), 32'd0);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_stat(input string name, input bit zero_bus);
    stat_t s;
    s.kind = 0; s.name = name;
    s.loaded = m_loaded; s.err = m_err; s.busy = bus.ROMINIT_SEL_BOOT | bus.ROMINIT_SEL_CHR | bus.ROMINIT_SEL_CART;
    s.busy = (name == "mid_boot");
    s.cart_len = m_cart_len; s.cksum = m_cksum;
    s.wr0 = m_wr[0]; s.wr1 = m_wr[1]; s.wr2 = m_wr[2];
    s.zero_bus = zero_bus;
    sq.push_back(s);
    m_wr[0] = 0; m_wr[1] = 0; m_wr[2] = 0;
  endtask

  task automatic set_sel(input logic [2:0] s);
    {bus.ROMINIT_SEL_CART, bus.ROMINIT_SEL_CHR, bus.ROMINIT_SEL_BOOT} = s;
  endtask

  task automatic idle();
    bus.ROMINIT_VALID = 1'b0;
    cyc();
  endtask

  task automatic do_reset(input string name);
    res = 1'b1;
    set_sel(3'b000);
    bus.ROMINIT_VALID = 1'b0;
    cyc(); cyc();
    res = 1'b0;
    m_loaded = '0; m_err = '0; m_cart_len = '0; m_cksum = '0;
    push_stat(name, 1'b1);
    cyc();
  endtask

  task automatic start_load(input logic [1:0] r);
    set_sel(3'b001 << r);
    bus.ROMINIT_VALID = 1'b0;
    cyc();
    m_rgn = r; m_expect = '0; m_count = '0; m_sum = 0;
    m_loaded[r] = 1'b0;
  endtask

  // One beat sampled in LOAD with the region select held
  task automatic beat(input logic [24:0] a, input logic [7:0] d);
    bus.ROMINIT_ADDR  = a;
    bus.ROMINIT_DATA  = d;
    bus.ROMINIT_VALID = 1'b1;
    if (a != m_expect) m_err[1] = 1'b1;
    m_expect = a + 25'd1;
    if (int'(a) >= (1 << aw_of(m_rgn))) begin
      m_err[0] = 1'b1;
    end else begin
      wq.push_back('{rgn: m_rgn, a: 17'(a), d: d});
      m_wr[m_rgn]++;
      if (m_count != '1) m_count = m_count + 18'd1;
      m_sum = (m_sum + int'(d)) % 65536;
    end
    cyc();
  endtask

  task automatic finish_load(input string name);
    set_sel(3'b000);
    bus.ROMINIT_VALID = 1'b0;
    cyc(); cyc();
    m_loaded[m_rgn] = 1'b1;
    if (m_rgn == 2'd2) m_cart_len = m_count;
`ifdef SCV_ROMINIT_CKSUM_EN
    m_cksum = 16'(m_sum);
`else
    m_cksum = 16'd0;
`endif
    push_stat(name, 1'b0);
    cyc();
  endtask

  initial begin
    stat_t fin;
    res = 1'b1;
    set_sel(3'b000);
    bus.ROMINIT_ADDR = '0; bus.ROMINIT_DATA = '0; bus.ROMINIT_VALID = 1'b0;
    m_wr[0] = 0; m_wr[1] = 0; m_wr[2] = 0;
    m_rgn = '0; m_expect = '0; m_count = '0; m_sum = 0;
    seen[0] = 0; seen[1] = 0; seen[2] = 0;
    cyc();
    do_reset("reset");

    // Stray beat in IDLE is ignored
    bus.ROMINIT_ADDR = 25'd5; bus.ROMINIT_VALID = 1'b1;
    cyc();
    idle();

    // Boot: full sequential load, data = addr[7:0]
    start_load(2'd0);
    for (int i = 0; i < 4096; i++) begin
      beat(25'(i), 8'(i));
      if (i == 2000) push_stat("mid_boot", 1'b0);
    end
    finish_load("boot");

    // Cart: 8192 random bytes with random VALID gaps
    do_reset("reset2");
    start_load(2'd2);
    for (int i = 0; i < 8192; i++) begin
      while ($urandom_range(0, 3) == 0) idle();
      beat(25'(i), 8'($urandom));
    end
    finish_load("cart");

    // CHR overflow: 1100 beats into a 1 KiB region
    do_reset("reset3");
    start_load(2'd1);
    for (int i = 0; i < 1100; i++) beat(25'(i), 8'($urandom));
    finish_load("chr_over");

    // Sequence gap on boot
    do_reset("reset4");
    start_load(2'd0);
    beat(25'd0, 8'hA5);
    beat(25'd1, 8'h5A);
    idle();
    beat(25'd3, 8'h3C);
    finish_load("seq_gap");

    // Multi-select in IDLE
    do_reset("reset5");
    set_sel(3'b101);
    bus.ROMINIT_VALID = 1'b1;
    bus.ROMINIT_ADDR = '0;
    cyc(); cyc();
    set_sel(3'b000);
    bus.ROMINIT_VALID = 1'b0;
    cyc();
    m_err[2] = 1'b1;
    push_stat("multi_idle", 1'b0);
    cyc();

    // Second select raised mid-load keeps the latched region
    do_reset("reset6");
    start_load(2'd1);
    beat(25'd0, 8'h11);
    set_sel(3'b011);
    m_err[2] = 1'b1;
    beat(25'd1, 8'h22);
    set_sel(3'b010);
    beat(25'd2, 8'h33);
    finish_load("multi_load");

    // Reset mid-cart, then a clean 256-byte reload ending on a coincident beat
    start_load(2'd2);
    for (int i = 0; i < 100; i++) beat(25'(i), 8'($urandom));
    res = 1'b1;
    set_sel(3'b000);
    bus.ROMINIT_ADDR = 25'd100; bus.ROMINIT_VALID = 1'b1;
    cyc();
    bus.ROMINIT_VALID = 1'b0;
    cyc();
    res = 1'b0;
    m_loaded = '0; m_err = '0; m_cart_len = '0; m_cksum = '0;
    push_stat("reset_mid_cart", 1'b1);
    cyc();
    start_load(2'd2);
    for (int i = 0; i < 256; i++) beat(25'(i), 8'($urandom));
    bus.ROMINIT_ADDR = 25'd256; bus.ROMINIT_DATA = 8'hEE; bus.ROMINIT_VALID = 1'b1;
    set_sel(3'b000);
    cyc(); cyc();
    bus.ROMINIT_VALID = 1'b0;
    m_loaded[2] = 1'b1;
    m_cart_len = m_count;
`ifdef SCV_ROMINIT_CKSUM_EN
    m_cksum = 16'(m_sum);
`else
    m_cksum = 16'd0;
`endif
    push_stat("cart_reload", 1'b0);
    cyc(); cyc();

    fin.kind = 1; fin.name = "end";
    sq.push_back(fin);
    repeat (10) cyc();
    $display("FAIL end_of_run: monitor did not reach summary, pending %0d", sq.size());
    $fatal(1);
  end
endmodule
